// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          PC_W             = 32;
   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   // Instruction fetches are word aligned; low address bits are discarded.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return addr & ~(PC_W'(3));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : single-outstanding instruction fetch with skid entry   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [PC_W-1:0]    dec_pc,
   input  logic               dec_ready
);

   fetch_state_e       state_q,      state_d;
   logic [PC_W-1:0]    pc_q,         pc_d;
   logic [PC_W-1:0]    fetch_pc_q,   fetch_pc_d;
   logic               dec_valid_q,  dec_valid_d;
   logic [INSTR_W-1:0] dec_instr_q,  dec_instr_d;
   logic [PC_W-1:0]    dec_pc_q,     dec_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;

   logic slot_free;
   logic transfer;

   assign slot_free = !dec_valid_q || dec_ready;
   assign transfer  = dec_valid_q && dec_ready;

   assign imem_req  = (state_q == ST_REQ) && !redirect_valid && rst_n;
   assign imem_addr = pc_q;
   assign dec_valid = dec_valid_q;
   assign dec_instr = dec_instr_q;
   assign dec_pc    = dec_pc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         fetch_pc_q   <= '0;
         dec_valid_q  <= 1'b0;
         dec_instr_q  <= '0;
         dec_pc_q     <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_pc_q   <= fetch_pc_d;
         dec_valid_q  <= dec_valid_d;
         dec_instr_q  <= dec_instr_d;
         dec_pc_q     <= dec_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      dec_valid_d  = dec_valid_q;
      dec_instr_d  = dec_instr_q;
      dec_pc_d     = dec_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      // A consumed word leaves the slot empty unless a load below refills it.
      if (transfer) begin
         dec_valid_d = 1'b0;
      end

      if (redirect_valid) begin
         pc_d         = align_pc(redirect_pc);
         dec_valid_d  = 1'b0;
         skid_instr_d = '0;
         skid_pc_d    = '0;
         // A request still in flight must be drained before refetching.
         unique case (state_q)
            ST_WAIT:  state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
            ST_DRAIN: state_d = ST_DRAIN;
            default:  state_d = ST_REQ;
         endcase
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (imem_gnt) begin
                  fetch_pc_d = pc_q;
                  pc_d       = pc_q + PC_INCR;
                  state_d    = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (slot_free) begin
                     dec_instr_d = imem_rdata;
                     dec_pc_d    = fetch_pc_q;
                     dec_valid_d = 1'b1;
                     state_d     = ST_REQ;
                  end else begin
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = fetch_pc_q;
                     state_d      = ST_STALL;
                  end
               end
            end
            ST_STALL: begin
               if (dec_ready) begin
                  dec_instr_d = skid_instr_q;
                  dec_pc_d    = skid_pc_q;
                  dec_valid_d = 1'b1;
                  state_d     = ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (imem_rvalid) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage : randomized bench with a program-order fetch model   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

   localparam logic [31:0] C_RESET_PC0 = 32'h0000_0000;
   localparam logic [31:0] C_RESET_PC1 = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid, dec_valid, dec_ready;
   logic [31:0] redirect_pc, dec_instr, dec_pc;

   logic        rst1_n, req1, gnt1, rvalid1, dvalid1, redir1, ready1;
   logic [31:0] addr1, rdata1, rpc1, dinstr1, dpc1;

   int n_checks = 0;
   int n_errors = 0;

   // memory responder knobs and manual override
   bit          mem_auto = 1'b1;
   int          gnt_pct  = 100;
   int          lat_min  = 1;
   int          lat_max  = 1;
   logic        auto_gnt, auto_rvalid, man_gnt, man_rvalid;
   logic [31:0] auto_rdata, man_rdata;

   assign imem_gnt    = mem_auto ? auto_gnt    : man_gnt;
   assign imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
   assign imem_rdata  = mem_auto ? auto_rdata  : man_rdata;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(C_RESET_PC0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .dec_ready(dec_ready)
   );

   fetch_stage #(.RESET_PC(C_RESET_PC1)) dut_wrap (
      .clk(clk), .rst_n(rst1_n),
      .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
      .imem_rvalid(rvalid1), .imem_rdata(rdata1),
      .redirect_valid(redir1), .redirect_pc(rpc1),
      .dec_valid(dvalid1), .dec_instr(dinstr1), .dec_pc(dpc1),
      .dec_ready(ready1)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive_cycle(input logic rst_v, input logic rdy, input logic redir,
                              input logic [31:0] rpc);
      @(negedge clk);
      rst_n          = rst_v;
      dec_ready      = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
   endtask

   task automatic wait_fire();
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
         seen = imem_req && imem_gnt;
      end
      check_eq("fire_seen", {31'b0, seen}, 32'd1);
   endtask

   task automatic wait_dec(output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
         cycles++;
         seen = dec_valid;
      end
      check_eq("dec_seen", {31'b0, seen}, 32'd1);
   endtask

   // Instruction memory: grants at random, answers one request after 1..N cycles.
   initial begin
      bit          out_busy = 1'b0;
      bit          rv;
      int          lat_cnt  = 0;
      logic [31:0] out_addr = '0;
      auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_auto) begin
            rv = 1'b0;
            if (out_busy) begin
               lat_cnt--;
               rv = (lat_cnt == 0);
            end
            auto_rvalid = rv;
            auto_rdata  = rv ? mem_word(out_addr) : $urandom;
            auto_gnt    = ($urandom_range(99) < gnt_pct);
            #2;
            if (!rst_n) begin
               out_busy = 1'b0;
            end else begin
               if (rv) out_busy = 1'b0;
               if (imem_req) check_eq("one_outstanding", {31'b0, out_busy}, 32'd0);
               if (imem_req && imem_gnt) begin
                  out_busy = 1'b1;
                  out_addr = imem_addr;
                  lat_cnt  = $urandom_range(lat_max, lat_min);
               end
            end
         end else begin
            out_busy = 1'b0;
            auto_gnt = 1'b0; auto_rvalid = 1'b0;
         end
      end
   end

   // Reference model: decode sees consecutive words in program order from the
   // reset PC or the last redirect target; fetches follow the same order.
   initial begin
      logic [31:0] exp_pc = C_RESET_PC0, exp_fetch = C_RESET_PC0;
      logic [31:0] h_pc = '0, h_instr = '0;
      bit          hold = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            check_eq("req_in_reset", {31'b0, imem_req}, 32'd0);
            exp_pc = C_RESET_PC0; exp_fetch = C_RESET_PC0; hold = 1'b0;
         end else begin
            if (hold) begin
               check_eq("hold_valid", {31'b0, dec_valid}, 32'd1);
               check_eq("hold_pc", dec_pc, h_pc);
               check_eq("hold_instr", dec_instr, h_instr);
            end
            if (dec_valid && dec_ready) begin
               check_eq("dec_pc_order", dec_pc, exp_pc);
               check_eq("dec_instr_data", dec_instr, mem_word(exp_pc));
               exp_pc += 32'd4;
            end
            if (redirect_valid) check_eq("req_on_redirect", {31'b0, imem_req}, 32'd0);
            if (imem_req && imem_gnt) begin
               check_eq("fetch_addr", imem_addr, exp_fetch);
               exp_fetch += 32'd4;
            end
            if (redirect_valid) begin
               exp_pc    = redirect_pc & ~32'd3;
               exp_fetch = redirect_pc & ~32'd3;
            end
            hold    = dec_valid && !dec_ready && !redirect_valid;
            h_pc    = dec_pc;
            h_instr = dec_instr;
         end
      end
   end

   // Second instance starting just below the top of the address space.
   logic [31:0] wrap_addr [3];
   int          n_wrap = 0;
   initial begin
      bit fire1 = 1'b0;
      rst1_n = 1'b0; gnt1 = 1'b1; rvalid1 = 1'b0; rdata1 = '0;
      ready1 = 1'b1; redir1 = 1'b0; rpc1 = '0;
      @(negedge clk);
      @(negedge clk);
      rst1_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #2;
         fire1 = req1 && gnt1;
         if (fire1 && n_wrap < 3) begin
            wrap_addr[n_wrap] = addr1;
            n_wrap++;
         end
         @(negedge clk);
         rvalid1 = fire1;
         rdata1  = $urandom;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int          cyc_at [4];
      logic [31:0] pc_at  [4];
      int          n_seen = 0;
      int          dly;
      logic [31:0] p0, i0;

      rst_n = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

      // Reset values
      repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
      check_eq("rst_dec_pc", dec_pc, 32'h0);
      check_eq("rst_dec_instr", dec_instr, 32'h0);
      check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);

      // First request right after reset, then back-to-back stream
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("first_req", {31'b0, imem_req}, 32'd1);
      check_eq("first_addr", imem_addr, C_RESET_PC0);
      for (int i = 1; i <= 20; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (dec_valid && n_seen < 4) begin
            cyc_at[n_seen] = i;
            pc_at[n_seen]  = dec_pc;
            n_seen++;
         end
      end
      check_eq("stream_count", n_seen, 4);
      for (int k = 0; k < n_seen; k++) begin
         check_eq("stream_pc", pc_at[k], C_RESET_PC0 + 32'(4 * k));
         if (k > 0) check_eq("stream_gap", cyc_at[k] - cyc_at[k-1], 2);
      end

      // Decode back-pressure: outputs frozen, one word parked, no fetching
      n_seen = 0;
      for (int i = 0; i < 20 && n_seen == 0; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
         if (dec_valid) n_seen = 1;
      end
      check_eq("stall_start", n_seen, 1);
      p0 = dec_pc;
      i0 = dec_instr;
      for (int i = 1; i <= 5; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
         check_eq("stall_valid", {31'b0, dec_valid}, 32'd1);
         check_eq("stall_pc", dec_pc, p0);
         check_eq("stall_instr", dec_instr, i0);
         if (i >= 2) check_eq("stall_no_req", {31'b0, imem_req}, 32'd0);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("release_pc", dec_pc, p0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("skid_valid", {31'b0, dec_valid}, 32'd1);
      check_eq("skid_pc", dec_pc, p0 + 32'd4);
      check_eq("skid_instr", dec_instr, mem_word(p0 + 32'd4));

      // Redirect while waiting on a slow response
      lat_min = 3; lat_max = 3;
      repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      wait_fire();
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("wait_no_req", {31'b0, imem_req}, 32'd0);
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      check_eq("redir_no_rvalid", {31'b0, imem_rvalid}, 32'd0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("drain_no_req", {31'b0, imem_req}, 32'd0);
      check_eq("drain_rvalid", {31'b0, imem_rvalid}, 32'd1);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("redir_req", {31'b0, imem_req}, 32'd1);
      check_eq("redir_addr", imem_addr, 32'h0000_0100);
      wait_dec(dly);
      check_eq("redir_dec_pc", dec_pc, 32'h0000_0100);

      // Redirect coincident with the response: no drain cycle
      lat_min = 1; lat_max = 1;
      repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      wait_fire();
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      check_eq("coinc_rvalid", {31'b0, imem_rvalid}, 32'd1);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("coinc_req", {31'b0, imem_req}, 32'd1);
      check_eq("coinc_addr", imem_addr, 32'h0000_0200);
      wait_dec(dly);
      check_eq("coinc_dec_pc", dec_pc, 32'h0000_0200);
      check_eq("coinc_min_lat", {31'b0, (dly + 1) >= 2}, 32'd1);

      // Reset in WAIT with a late response straight after
      mem_auto = 1'b0;
      repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      man_gnt = 1'b1;
      check_eq("r38_req", {31'b0, imem_req}, 32'd1);
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      man_gnt = 1'b0;
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      man_rvalid = 1'b1;
      man_rdata  = 32'hBAD0_BAD0;
      check_eq("r38_req_after_rst", {31'b0, imem_req}, 32'd1);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      man_rvalid = 1'b0;
      man_gnt    = 1'b1;
      check_eq("r38_late_ignored", {31'b0, dec_valid}, 32'd0);
      check_eq("r38_refetch_addr", imem_addr, C_RESET_PC0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      man_gnt    = 1'b0;
      man_rvalid = 1'b1;
      man_rdata  = mem_word(C_RESET_PC0);
      check_eq("r38_still_empty", {31'b0, dec_valid}, 32'd0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      man_rvalid = 1'b0;
      check_eq("r38_valid", {31'b0, dec_valid}, 32'd1);
      check_eq("r38_pc", dec_pc, C_RESET_PC0);
      check_eq("r38_instr", dec_instr, mem_word(C_RESET_PC0));
      mem_auto = 1'b1;

      // Random traffic against the reference model
      gnt_pct = 60; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         drive_cycle($urandom_range(199) != 0, $urandom_range(9) < 7,
                     $urandom_range(19) == 0, $urandom);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // PC wrap on the second instance
      check_eq("wrap_count", {31'b0, n_wrap >= 3}, 32'd1);
      for (int k = 0; k < n_wrap; k++) begin
         check_eq("wrap_addr", wrap_addr[k], C_RESET_PC1 + 32'(4 * k));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
